// File: rtl/controlador_dispensador.sv
// Vending-machine control stage after the coin adder: price check, dispense, change and refund.
// Optional idle-credit timeout refund enabled by defining DISPENSADOR_TIMEOUT_EN.
module controlador_dispensador #(
  parameter int unsigned PRECIO0        = 100,
  parameter int unsigned PRECIO1        = 150,
  parameter int unsigned PRECIO2        = 200,
  parameter int unsigned PRECIO3        = 250,
  parameter int unsigned DISP_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] monto,
  input  logic [1:0]  sel,
  input  logic        comprar,
  input  logic        cancelar,
  output logic        enable,
  output logic        clr_monto,
  output logic        dispensar,
  output logic [1:0]  producto,
  output logic [11:0] vuelto,
  output logic        vuelto_valid,
  output logic        error_fondos
);

  localparam int unsigned MW = 12;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4,
    FAIL     = 3'd5
  } estado_t;

  estado_t        estado, estado_d;
  logic [MW-1:0]  monto_q, monto_q_d;
  logic [SW-1:0]  sel_q, sel_q_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [MW-1:0]  precio;
  logic           vencido;

  logic           enable_d, clr_monto_d, dispensar_d, vuelto_valid_d, error_fondos_d;
  logic [SW-1:0]  producto_d;
  logic [MW-1:0]  vuelto_d;

  // Price lookup for the latched selector
  always_comb begin
    precio = MW'(PRECIO0);
    case (sel_q)
      2'd0: precio = MW'(PRECIO0);
      2'd1: precio = MW'(PRECIO1);
      2'd2: precio = MW'(PRECIO2);
      2'd3: precio = MW'(PRECIO3);
      default: precio = MW'(PRECIO0);
    endcase
  end

`ifdef DISPENSADOR_TIMEOUT_EN
  logic [CW-1:0] to_cnt, to_cnt_d;
  logic          esperando;

  // Idle credit sitting with no request counts toward an automatic refund
  assign esperando = (estado == IDLE) && (monto != '0) && !comprar && !cancelar;
  assign vencido   = esperando && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (esperando) to_cnt_d = to_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt <= '0;
    else      to_cnt <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign vencido        = 1'b0;
`endif

  // Next state, latched operands and next values of the registered outputs
  always_comb begin
    estado_d   = estado;
    monto_q_d  = monto_q;
    sel_q_d    = sel_q;
    cnt_d      = cnt;
    producto_d = producto;
    vuelto_d   = vuelto;

    case (estado)
      IDLE: begin
        if (cancelar || vencido) begin
          estado_d = REFUND;
          vuelto_d = monto;
        end else if (comprar) begin
          estado_d  = CHECK;
          monto_q_d = monto;
          sel_q_d   = sel;
        end
      end
      CHECK: begin
        if (monto_q >= precio) begin
          estado_d   = DISPENSE;
          cnt_d      = CW'(DISP_CYCLES - 1);
          producto_d = sel_q;
        end else begin
          estado_d = FAIL;
        end
      end
      DISPENSE: begin
        if (cnt == '0) begin
          estado_d = CHANGE;
          vuelto_d = monto_q - precio;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      CHANGE:  estado_d = IDLE;
      REFUND:  estado_d = IDLE;
      FAIL:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase

    enable_d       = (estado_d == IDLE);
    dispensar_d    = (estado_d == DISPENSE);
    vuelto_valid_d = (estado_d == CHANGE) || (estado_d == REFUND);
    clr_monto_d    = vuelto_valid_d;
    error_fondos_d = (estado_d == FAIL);
  end

  // State, operand and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado       <= IDLE;
      monto_q      <= '0;
      sel_q        <= '0;
      cnt          <= '0;
      enable       <= 1'b1;
      clr_monto    <= 1'b0;
      dispensar    <= 1'b0;
      producto     <= '0;
      vuelto       <= '0;
      vuelto_valid <= 1'b0;
      error_fondos <= 1'b0;
    end else begin
      estado       <= estado_d;
      monto_q      <= monto_q_d;
      sel_q        <= sel_q_d;
      cnt          <= cnt_d;
      enable       <= enable_d;
      clr_monto    <= clr_monto_d;
      dispensar    <= dispensar_d;
      producto     <= producto_d;
      vuelto       <= vuelto_d;
      vuelto_valid <= vuelto_valid_d;
      error_fondos <= error_fondos_d;
    end
  end

endmodule

// File: tb/tb_controlador_dispensador.sv
// Directed self-checking bench for controlador_dispensador.
// Define DISPENSADOR_TIMEOUT_EN to exercise the idle-timeout refund.
module tb_controlador_dispensador;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] monto;
  logic [1:0]  sel;
  logic        comprar;
  logic        cancelar;
  logic        enable;
  logic        clr_monto;
  logic        dispensar;
  logic [1:0]  producto;
  logic [11:0] vuelto;
  logic        vuelto_valid;
  logic        error_fondos;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  controlador_dispensador #(
    .PRECIO0(100), .PRECIO1(150), .PRECIO2(200), .PRECIO3(250),
    .DISP_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .monto(monto), .sel(sel),
    .comprar(comprar), .cancelar(cancelar),
    .enable(enable), .clr_monto(clr_monto), .dispensar(dispensar),
    .producto(producto), .vuelto(vuelto), .vuelto_valid(vuelto_valid),
    .error_fondos(error_fondos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic en, input logic clr,
                         input logic disp, input logic vv, input logic err);
    check({tag, ".enable"},       32'(enable),       32'(en));
    check({tag, ".clr_monto"},    32'(clr_monto),    32'(clr));
    check({tag, ".dispensar"},    32'(dispensar),    32'(disp));
    check({tag, ".vuelto_valid"}, 32'(vuelto_valid), 32'(vv));
    check({tag, ".error_fondos"}, 32'(error_fondos), 32'(err));
  endtask

  // Full successful purchase; optionally pulses cancelar on dispense cycle cancel_at
  task automatic compra_ok(input string tag, input logic [11:0] m, input logic [1:0] s,
                           input logic [11:0] exp_vuelto, input int cancel_at);
    monto = m; sel = s; comprar = 1'b1;
    step();
    comprar = 1'b0;
    strobes({tag, ".check"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cancelar = (i == cancel_at);
      step();
      strobes({tag, ".disp"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check({tag, ".producto"}, 32'(producto), 32'(s));
    end
    cancelar = 1'b0;
    step();
    strobes({tag, ".change"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check({tag, ".vuelto"}, 32'(vuelto), 32'(exp_vuelto));
    monto = '0;
    step();
    strobes({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, ".vuelto_hold"}, 32'(vuelto), 32'(exp_vuelto));
  endtask

  initial begin
    rst = 1'b0; monto = '0; sel = '0; comprar = 1'b0; cancelar = 1'b0;
    step(2);
    strobes("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.vuelto", 32'(vuelto), 32'd0);
    check("reset.producto", 32'(producto), 32'd0);
    rst = 1'b1;
    step();

    compra_ok("buy180s1", 12'd180, 2'd1, 12'd30, -1);
    compra_ok("exact250s3", 12'd250, 2'd3, 12'd0, -1);

    // Insufficient credit: 120 < 200
    monto = 12'd120; sel = 2'd2; comprar = 1'b1;
    step();
    comprar = 1'b0;
    strobes("fail.check", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    strobes("fail.err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    strobes("fail.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    monto = '0;
    step();

    // cancelar wins over simultaneous comprar
    monto = 12'd70; comprar = 1'b1; cancelar = 1'b1;
    step();
    comprar = 1'b0; cancelar = 1'b0;
    strobes("prio.refund", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("prio.vuelto", 32'(vuelto), 32'd70);
    monto = '0;
    step();
    strobes("prio.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of DISPENSE
    monto = 12'd220; sel = 2'd2; comprar = 1'b1;
    step();
    comprar = 1'b0;
    step();
    check("rstmid.disp_before", 32'(dispensar), 32'd1);
    check("rstmid.producto_before", 32'(producto), 32'd2);
    rst = 1'b0;
    #1;
    strobes("rstmid.async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstmid.vuelto", 32'(vuelto), 32'd0);
    check("rstmid.producto", 32'(producto), 32'd0);
    monto = '0;
    step();
    rst = 1'b1;
    step();
    strobes("rstmid.release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4);
    strobes("rstmid.quiet", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Refund with zero credit still pulses
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    strobes("refund0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("refund0.vuelto", 32'(vuelto), 32'd0);
    step();

    // cancelar during DISPENSE is ignored
    compra_ok("buy100s0_cancel", 12'd100, 2'd0, 12'd0, 2);
    step();
    strobes("cancel_ignored.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle credit timeout
    monto = 12'd50;
`ifdef DISPENSADOR_TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      step();
      check("timeout.vv", 32'(vuelto_valid), (i == 10) ? 32'd1 : 32'd0);
    end
    check("timeout.vuelto", 32'(vuelto), 32'd50);
    check("timeout.clr", 32'(clr_monto), 32'd1);
    monto = '0;
    step();
`else
    begin
      int pulses = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (vuelto_valid) pulses++;
      end
      check("notimeout.pulses", 32'(pulses), 32'd0);
      check("notimeout.enable", 32'(enable), 32'd1);
    end
    monto = '0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_dispensador.md
# controlador_dispensador

Vending-machine control stage directly downstream of the coin adder. It samples the accumulated `monto` and the product selector `sel` on a buy request, checks the price and holds the dispense strobe. It then reports the change and clears the adder. It also drives the adder's `enable` so that coins are accepted only while the machine is idle.

## Interface
- `PRECIO0`, default 100: price of product 0, 12-bit units.
- `PRECIO1`, default 150: price of product 1.
- `PRECIO2`, default 200: price of product 2.
- `PRECIO3`, default 250: price of product 3.
- `DISP_CYCLES`, default 4: cycles `dispensar` is held high (≥1).
- `TIMEOUT_CYCLES`, default 1000: idle-timeout length; used only with the config macro.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `monto` in 12: accumulated credit from the coin adder.
- `sel` in 2: product selector.
- `comprar` in 1: buy request, level-sampled in IDLE.
- `cancelar` in 1: refund request, level-sampled in IDLE.
- `enable` out 1: coin-adder accept enable.
- `clr_monto` out 1: one-cycle clear strobe to the coin adder.
- `dispensar` out 1: dispense strobe.
- `producto` out 2: latched product index, valid while `dispensar`=1.
- `vuelto` out 12: change/refund amount, valid while `vuelto_valid`=1.
- `vuelto_valid` out 1: one-cycle change-valid strobe.
- `error_fondos` out 1: one-cycle insufficient-credit strobe.

## Operation
- **States:** IDLE, CHECK, DISPENSE, CHANGE, REFUND, FAIL.
- **Outputs:** all outputs are registered or decoded from the registered state; there are no combinational input-to-output paths.
- **IDLE:**
  - `enable`=1; every other strobe is 0.
  - `cancelar`=1 → REFUND. `cancelar` has priority over a simultaneous `comprar`.
  - `comprar`=1 → CHECK. On this transition, latch `monto_q`←`monto` and `sel_q`←`sel`.
- **CHECK:**
  - `enable`=0.
  - `precio` = PRECIO[`sel_q`].
  - `monto_q` ≥ `precio` → DISPENSE, and load the cycle counter with DISP_CYCLES-1.
  - Otherwise → FAIL.
- **DISPENSE:**
  - `dispensar`=1 and `producto`=`sel_q`.
  - The counter decrements each cycle. When it reaches 0 → CHANGE.
- **CHANGE:**
  - One cycle with `vuelto` = `monto_q` − `precio` (unsigned 12-bit; cannot underflow because CHECK guarantees it).
  - `vuelto_valid`=1 and `clr_monto`=1; → IDLE.
  - An exact payment still pulses `vuelto_valid`, with `vuelto`=0.
- **REFUND:**
  - One cycle with `vuelto`=`monto` (sampled on entry), `vuelto_valid`=1, `clr_monto`=1; → IDLE.
  - `monto`=0 still produces the pulse, with `vuelto`=0.
- **FAIL:**
  - One cycle with `error_fondos`=1; → IDLE.
  - `clr_monto` stays 0, so the credit is retained.
- **Inputs outside IDLE:** `comprar` and `cancelar` are ignored in every other state and are not queued. A request held high re-triggers on the first IDLE cycle.
- **`vuelto` between strobes:** holds its last value.

## Timing
- **Reset:** `rst`=0 asynchronously forces IDLE. Reset values:
  - `enable`=1.
  - `clr_monto`, `dispensar`, `vuelto_valid`, `error_fondos` = 0.
  - `producto`=0, `vuelto`=0, counters = 0.
- **Reset mid-transaction:** reset at any point aborts the transaction. No change strobe and no clear strobe are emitted.
- **Buy, sampled at edge N:**
  - CHECK at N+1.
  - `dispensar` high for edges N+2 .. N+1+DISP_CYCLES.
  - CHANGE strobes at N+2+DISP_CYCLES.
  - IDLE (`enable`=1) at N+3+DISP_CYCLES.
- **Failed buy, sampled at edge N:** CHECK at N+1, `error_fondos` at N+2, IDLE at N+3.
- **Cancel, sampled at edge N:** REFUND strobes at N+1, IDLE at N+2.
- **`enable` window:** `enable` drops the cycle after the sampling edge. A coin arriving on that same edge is already in `monto` but is not in `monto_q`. It is cleared by `clr_monto` on a successful purchase or a refund.

## Configuration
- **Macro:** `DISPENSADOR_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter increments in IDLE while `monto`≠0 and neither `comprar` nor `cancelar` is high.
  - The counter resets to 0 on any request, on `monto`=0, or outside IDLE.
  - When it reaches TIMEOUT_CYCLES-1 → REFUND, with the same behaviour as a user cancel.
- **Undefined:** no counter is built; credit is held indefinitely.

## Test plan
- **Reset:** assert `rst`=0 mid-DISPENSE → all outputs return to their reset values immediately; IDLE and `enable`=1 after release.
- **Successful buy with change:** `monto`=180, `sel`=1, pulse `comprar` → `dispensar` high 4 cycles with `producto`=1, then one cycle with `vuelto`=30, `vuelto_valid`=1, `clr_monto`=1.
- **Exact payment:** `monto`=250, `sel`=3 → dispense, then `vuelto`=0 with `vuelto_valid`=1.
- **Insufficient credit:** `monto`=120, `sel`=2, `comprar` → `error_fondos` for 1 cycle, no `dispensar`, no `clr_monto`; back in IDLE with `enable`=1.
- **Request priority and masking:**
  - `comprar` and `cancelar` high together with `monto`=70 → REFUND with `vuelto`=70, no dispense.
  - `cancelar` pulsed during DISPENSE → ignored.
- **Timeout, with `DISPENSADOR_TIMEOUT_EN` defined:** `TIMEOUT_CYCLES`=10, `monto`=50, idle → REFUND strobe with `vuelto`=50 after exactly 10 idle cycles. Without the macro, no strobe after 100 cycles.
